// File: rtl/wt_dcache_shct_predictor_if.sv
// Event and prediction bundle between the dcache miss logic
// and the SHCT reuse predictor.
interface wt_dcache_shct_predictor_if #(
    parameter int unsigned SigWidth = 14,
    parameter int unsigned CntWidth = 2
) ();
    logic                flush_i;
    logic                hit_i;
    logic [SigWidth-1:0] hit_sig_i;
    logic                evict_i;
    logic                evict_reused_i;
    logic [SigWidth-1:0] evict_sig_i;
    logic                fill_i;
    logic [SigWidth-1:0] fill_sig_i;
    logic                pred_req_i;
    logic [SigWidth-1:0] pred_sig_i;
    logic                pred_valid_o;
    logic                pred_reuse_o;
    logic [CntWidth-1:0] pred_cnt_o;
    logic                busy_o;

    modport master (
        output flush_i, hit_i, hit_sig_i,
        output evict_i, evict_reused_i, evict_sig_i,
        output fill_i, fill_sig_i,
        output pred_req_i, pred_sig_i,
        input  pred_valid_o, pred_reuse_o,
        input  pred_cnt_o, busy_o
    );

    modport slave (
        input  flush_i, hit_i, hit_sig_i,
        input  evict_i, evict_reused_i, evict_sig_i,
        input  fill_i, fill_sig_i,
        input  pred_req_i, pred_sig_i,
        output pred_valid_o, pred_reuse_o,
        output pred_cnt_o, busy_o
    );
endinterface

// File: rtl/wt_dcache_shct_predictor.sv
// Signature-history counter table for write-through dcache
// reuse prediction, with clear and aging sweeps.
module wt_dcache_shct_predictor #(
    parameter int unsigned SigWidth      = 14,
    parameter int unsigned CntWidth      = 2,
    parameter int unsigned PredThreshold = 1,
    parameter int unsigned FillVal       = 0,
    parameter int unsigned DecayPeriod   = 65536
) (
    input logic clk_i,
    input logic rst_ni,
    wt_dcache_shct_predictor_if.slave bus
);
    localparam int unsigned Depth = 2 ** SigWidth;
    localparam int unsigned TmrWidth =
        (DecayPeriod == 0) ? 1 : $clog2(DecayPeriod + 1);
    localparam logic [CntWidth-1:0] CntMax = '1;
    localparam logic [CntWidth-1:0] Fill = CntWidth'(FillVal);
    localparam logic [CntWidth-1:0] Thresh =
        CntWidth'(PredThreshold);
    localparam logic [TmrWidth-1:0] TmrLast =
        TmrWidth'((DecayPeriod == 0) ? 0 : DecayPeriod - 1);
    localparam bit DecayEn = (DecayPeriod != 0);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DECAY
    } state_e;

    state_e                state_q;
    logic [SigWidth-1:0]   idx_q;
    logic [TmrWidth-1:0]   tmr_q;
    logic                  busy_q;
    logic                  pred_valid_q;
    logic                  pred_reuse_q;
    logic [CntWidth-1:0]   pred_cnt_q;
    logic [CntWidth-1:0]   shct_q [Depth];

    logic idle;
    logic decay_due;
    logic hit_live;
    logic dead_live;
    logic fill_live;
    logic hit_do;
    logic dead_do;
    logic [CntWidth-1:0] hit_cnt;
    logic [CntWidth-1:0] dead_cnt;
    logic [CntWidth-1:0] pred_cnt;

    assign idle      = (state_q == IDLE);
    assign decay_due = DecayEn && (tmr_q == TmrLast);
    assign hit_live  = idle && bus.hit_i;
    assign dead_live = idle && bus.evict_i && !bus.evict_reused_i;
    assign fill_live = idle && bus.fill_i;

    // A fill wins its signature; a hit and a dead-evict cancel.
    assign hit_do = hit_live
        && !(dead_live && bus.evict_sig_i == bus.hit_sig_i)
        && !(fill_live && bus.fill_sig_i == bus.hit_sig_i);
    assign dead_do = dead_live
        && !(hit_live && bus.hit_sig_i == bus.evict_sig_i)
        && !(fill_live && bus.fill_sig_i == bus.evict_sig_i);

    assign hit_cnt  = shct_q[bus.hit_sig_i];
    assign dead_cnt = shct_q[bus.evict_sig_i];
    assign pred_cnt = shct_q[bus.pred_sig_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            tmr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.flush_i) begin
                        state_q <= CLEAR;
                        idx_q   <= '0;
                        tmr_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (decay_due) begin
                        state_q <= DECAY;
                        idx_q   <= '0;
                        tmr_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                CLEAR, DECAY: begin
                    if (bus.flush_i) begin
                        state_q <= CLEAR;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (idx_q == '1) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    idx_q   <= '0;
                    tmr_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Table has no reset; the clear sweep initialises it.
    always_ff @(posedge clk_i) begin
        if (state_q == CLEAR) begin
            shct_q[idx_q] <= '0;
        end else if (state_q == DECAY) begin
            shct_q[idx_q] <= shct_q[idx_q] >> 1;
        end else begin
            if (hit_do && hit_cnt != CntMax)
                shct_q[bus.hit_sig_i] <= hit_cnt + 1'b1;
            if (dead_do && dead_cnt != '0)
                shct_q[bus.evict_sig_i] <= dead_cnt - 1'b1;
            if (fill_live)
                shct_q[bus.fill_sig_i] <= Fill;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pred_valid_q <= 1'b0;
            pred_reuse_q <= 1'b0;
            pred_cnt_q   <= '0;
        end else begin
            pred_valid_q <= bus.pred_req_i;
            if (busy_q) begin
                pred_reuse_q <= 1'b0;
                pred_cnt_q   <= '0;
            end else begin
                pred_reuse_q <= (pred_cnt >= Thresh);
                pred_cnt_q   <= pred_cnt;
            end
        end
    end

    assign bus.busy_o       = busy_q;
    assign bus.pred_valid_o = pred_valid_q;
    assign bus.pred_reuse_o = pred_reuse_q;
    assign bus.pred_cnt_o   = pred_cnt_q;
endmodule

// File: tb/tb_wt_dcache_shct_predictor.sv
// Bench for the SHCT predictor: a default-sized instance and a
// small fast-aging instance, both checked against a table model.
module tb_wt_dcache_shct_predictor;
    localparam int CntMax = 3;
    localparam int Thr    = 1;
    localparam int FillV  = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wt_dcache_shct_predictor_if #(.SigWidth(14), .CntWidth(2)) ifa ();
    wt_dcache_shct_predictor_if #(.SigWidth(4), .CntWidth(2)) ifb ();

    wt_dcache_shct_predictor dut_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ifa)
    );

    wt_dcache_shct_predictor #(
        .SigWidth(4), .CntWidth(2), .PredThreshold(1),
        .FillVal(0), .DecayPeriod(64)
    ) dut_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ifb)
    );

    logic flush[2], hit[2], evict[2], reused[2], fill[2], req[2];
    logic [13:0] hsig[2], esig[2], fsig[2], psig[2];
    logic busy_w[2], valid_w[2], reuse_w[2];
    logic [1:0] cnt_w[2];

    assign ifa.flush_i        = flush[0];
    assign ifa.hit_i          = hit[0];
    assign ifa.hit_sig_i      = hsig[0];
    assign ifa.evict_i        = evict[0];
    assign ifa.evict_reused_i = reused[0];
    assign ifa.evict_sig_i    = esig[0];
    assign ifa.fill_i         = fill[0];
    assign ifa.fill_sig_i     = fsig[0];
    assign ifa.pred_req_i     = req[0];
    assign ifa.pred_sig_i     = psig[0];
    assign ifb.flush_i        = flush[1];
    assign ifb.hit_i          = hit[1];
    assign ifb.hit_sig_i      = hsig[1][3:0];
    assign ifb.evict_i        = evict[1];
    assign ifb.evict_reused_i = reused[1];
    assign ifb.evict_sig_i    = esig[1][3:0];
    assign ifb.fill_i         = fill[1];
    assign ifb.fill_sig_i     = fsig[1][3:0];
    assign ifb.pred_req_i     = req[1];
    assign ifb.pred_sig_i     = psig[1][3:0];
    assign busy_w[0]  = ifa.busy_o;
    assign valid_w[0] = ifa.pred_valid_o;
    assign reuse_w[0] = ifa.pred_reuse_o;
    assign cnt_w[0]   = ifa.pred_cnt_o;
    assign busy_w[1]  = ifb.busy_o;
    assign valid_w[1] = ifb.pred_valid_o;
    assign reuse_w[1] = ifb.pred_reuse_o;
    assign cnt_w[1]   = ifb.pred_cnt_o;

    int tests = 0;
    int fails = 0;

    // Model: table as sparse map (absent = 0), sweeps applied whole
    int unsigned tab[int unsigned];
    int busy_left[2];
    int idle_cnt[2];
    int exp_valid[2];
    int exp_cnt[2];
    int depth[2]  = '{16384, 16};
    int period[2] = '{65536, 64};

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int unsigned key(int d, int s);
        return int'(d) * 65536 + ((d == 1) ? (s & 15) : s);
    endfunction

    function automatic int rd(int d, int s);
        int unsigned k = key(d, s);
        return tab.exists(k) ? int'(tab[k]) : 0;
    endfunction

    task automatic start_sweep(int d, bit clear);
        int unsigned keys[$];
        busy_left[d] = depth[d];
        idle_cnt[d]  = 0;
        foreach (tab[k]) if (int'(k / 65536) == d) keys.push_back(k);
        foreach (keys[i]) begin
            if (clear) tab.delete(keys[i]);
            else tab[keys[i]] = tab[keys[i]] / 2;
        end
    endtask

    task automatic step(int d);
        int delta[int];
        int v;
        int hs = int'(hsig[d]);
        int es = int'(esig[d]);
        exp_valid[d] = int'(req[d]);
        exp_cnt[d] = (busy_left[d] > 0) ? 0 : rd(d, int'(psig[d]));
        if (busy_left[d] > 0) begin
            if (flush[d]) start_sweep(d, 1'b1);
            else begin
                busy_left[d]--;
                if (busy_left[d] == 0) idle_cnt[d] = 0;
            end
        end else begin
            if (hit[d]) delta[hs] = 1;
            if (evict[d] && !reused[d])
                delta[es] = (delta.exists(es) ? delta[es] : 0) - 1;
            foreach (delta[s]) begin
                v = rd(d, s) + delta[s];
                if (v < 0) v = 0;
                if (v > CntMax) v = CntMax;
                tab[key(d, s)] = v;
            end
            if (fill[d]) tab[key(d, int'(fsig[d]))] = FillV;
            if (flush[d]) start_sweep(d, 1'b1);
            else if (period[d] != 0 && idle_cnt[d] == period[d] - 1)
                start_sweep(d, 1'b0);
            else idle_cnt[d]++;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tab.delete();
            for (int d = 0; d < 2; d++) begin
                busy_left[d] = depth[d];
                idle_cnt[d]  = 0;
                exp_valid[d] = 0;
                exp_cnt[d]   = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) step(d);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy[%0d]", d), int'(busy_w[d]),
                    int'(busy_left[d] > 0));
                chk($sformatf("valid[%0d]", d), int'(valid_w[d]),
                    exp_valid[d]);
                if (exp_valid[d] != 0) begin
                    chk($sformatf("cnt[%0d]", d), int'(cnt_w[d]),
                        exp_cnt[d]);
                    chk($sformatf("reuse[%0d]", d), int'(reuse_w[d]),
                        int'(exp_cnt[d] >= Thr));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in(int d);
        flush[d] = 0; hit[d] = 0; evict[d] = 0; reused[d] = 0;
        fill[d] = 0; req[d] = 0;
        hsig[d] = '0; esig[d] = '0; fsig[d] = '0; psig[d] = '0;
    endtask

    task automatic pred_chk(int d, int s, int exp, string name);
        req[d] = 1'b1;
        psig[d] = 14'(s);
        cyc();
        req[d] = 1'b0;
        chk({name, "_valid"}, int'(valid_w[d]), 1);
        chk({name, "_cnt"}, int'(cnt_w[d]), exp);
        chk({name, "_reuse"}, int'(reuse_w[d]), int'(exp >= Thr));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clr_in(0);
        clr_in(1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy_w[0]), 1);
        chk("rst_valid", int'(valid_w[0]), 0);
        chk("rst_cnt", int'(cnt_w[0]), 0);
        chk("rst_reuse", int'(reuse_w[0]), 0);
        chk("rst_busy_b", int'(busy_w[1]), 1);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (busy_w[0] && n < 20000) begin cyc(); n++; end
        chk("clear_cycles", n, 16384);

        pred_chk(0, 'h1234, 0, "after_clear");
        hit[0] = 1; hsig[0] = 14'h5;
        repeat (4) cyc();
        hit[0] = 0;
        pred_chk(0, 5, 3, "hit_sat");
        evict[0] = 1; esig[0] = 14'h5;
        repeat (4) cyc();
        evict[0] = 0;
        pred_chk(0, 5, 0, "evict_floor");
        hit[0] = 1;
        repeat (2) cyc();
        hit[0] = 0; evict[0] = 1; reused[0] = 1;
        cyc();
        evict[0] = 0; reused[0] = 0;
        pred_chk(0, 5, 2, "reused_evict");

        hit[0] = 1; hsig[0] = 14'hAA;
        repeat (2) cyc();
        evict[0] = 1; esig[0] = 14'hAA;
        cyc();
        clr_in(0);
        pred_chk(0, 'hAA, 2, "hit_dead_cancel");
        hit[0] = 1; hsig[0] = 14'hAA;
        evict[0] = 1; esig[0] = 14'hAA;
        fill[0] = 1; fsig[0] = 14'hAA;
        cyc();
        clr_in(0);
        pred_chk(0, 'hAA, 0, "fill_wins");
        hit[0] = 1; hsig[0] = 14'h2;
        cyc();
        hsig[0] = 14'h1; evict[0] = 1; esig[0] = 14'h2;
        cyc();
        clr_in(0);
        pred_chk(0, 1, 1, "dual_hit");
        pred_chk(0, 2, 0, "dual_evict");

        hit[0] = 1; hsig[0] = 14'h10;
        cyc();
        pred_chk(0, 'h10, 1, "pred_pre_update");
        hit[0] = 0;
        pred_chk(0, 'h10, 2, "pred_post_update");

        flush[1] = 1;
        cyc();
        flush[1] = 0;
        chk("b_flush_busy", int'(busy_w[1]), 1);
        n = 0;
        while (busy_w[1] && n < 200) begin cyc(); n++; end
        chk("b_clear_cycles", n, 16);
        hit[1] = 1; hsig[1] = 14'h3;
        repeat (3) cyc();
        hit[1] = 0;
        n = 3;
        while (!busy_w[1] && n < 200) begin cyc(); n++; end
        chk("b_decay_period", n, 64);
        hit[1] = 1;
        cyc();
        hit[1] = 0;
        n = 1;
        while (busy_w[1] && n < 200) begin cyc(); n++; end
        chk("b_decay_cycles", n, 16);
        pred_chk(1, 3, 1, "b_decayed");

        hit[1] = 1; hsig[1] = 14'h5;
        repeat (3) cyc();
        hit[1] = 0;
        n = 0;
        while (!busy_w[1] && n < 200) begin cyc(); n++; end
        repeat (7) cyc();
        flush[1] = 1;
        cyc();
        flush[1] = 0;
        n = 8;
        while (busy_w[1] && n < 200) begin cyc(); n++; end
        chk("b_flush_restart", n, 24);
        for (int i = 0; i < 16; i++)
            pred_chk(1, i, 0, $sformatf("b_zero%0d", i));

        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                int mx = (d == 0) ? 7 : 15;
                flush[d]  = (d == 1) && ($urandom_range(0, 399) == 0);
                hit[d]    = $urandom_range(0, 1) == 1;
                evict[d]  = $urandom_range(0, 1) == 1;
                reused[d] = $urandom_range(0, 3) == 0;
                fill[d]   = $urandom_range(0, 5) == 0;
                req[d]    = $urandom_range(0, 2) != 0;
                hsig[d] = 14'($urandom_range(0, mx));
                esig[d] = 14'($urandom_range(0, mx));
                fsig[d] = 14'($urandom_range(0, mx));
                psig[d] = 14'($urandom_range(0, mx));
            end
            cyc();
        end
        clr_in(0);
        clr_in(1);
        repeat (4) cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wt_dcache_shct_predictor.md
Name: wt_dcache_shct_predictor

Overview:
Parametrised signature-history counter table (SHCT) for write-through dcache reuse prediction, replacing the fixed 16K x 2-bit predictor.
- Generalised: signature width, counter width, prediction threshold and fill value are parameters.
- Added: registered prediction with request/valid timing; a multi-cycle clear sweep (flush and reset) so the table needs no reset network; a periodic aging sweep that halves all counters.
- Sits beside the dcache miss/replacement logic: it consumes hit/evict/fill events and drives the insertion-priority decision.

Parameters:
SigWidth, 14, signature width; table depth is 2**SigWidth entries.
CntWidth, 2, saturating counter width; CntMax = 2**CntWidth-1.
PredThreshold, 1, counter >= threshold predicts reuse (1..CntMax).
FillVal, 0, value written to the filled signature's counter on fill.
DecayPeriod, 65536, idle cycles between aging sweeps; 0 disables aging.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
flush_i  in  1  single-cycle pulse; starts (or restarts) a clear sweep.
hit_i  in  1  cache hit on a line; increment counter of hit_sig_i.
hit_sig_i  in  SigWidth  signature of the hit line.
evict_i  in  1  line evicted.
evict_reused_i  in  1  evicted line had been re-referenced since fill.
evict_sig_i  in  SigWidth  signature of the evicted line.
fill_i  in  1  new line inserted.
fill_sig_i  in  SigWidth  signature of the filled line.
pred_req_i  in  1  prediction request.
pred_sig_i  in  SigWidth  signature to predict.
pred_valid_o  out  1  prediction valid, one cycle after pred_req_i.
pred_reuse_o  out  1  1 = near reuse, 0 = distant reuse.
pred_cnt_o  out  CntWidth  raw counter value behind the prediction.
busy_o  out  1  a clear or decay sweep is in progress.

Behaviour:
- Reset (async, rst_ni=0):
  - FSM enters CLEAR with sweep index 0 and decay timer 0.
  - busy_o=1; pred_valid_o=0; pred_reuse_o=0; pred_cnt_o=0.
  - Table storage is not reset.
- FSM states:
  - IDLE -> CLEAR on flush_i.
  - IDLE -> DECAY when DecayPeriod!=0 and the decay timer reaches DecayPeriod-1.
  - CLEAR: writes 0 to entry[idx] each cycle, idx 0..2**SigWidth-1; enters IDLE the cycle after the last index.
  - DECAY: writes entry[idx] >> 1 each cycle over the same range, then enters IDLE.
  - flush_i in CLEAR or DECAY resets idx to 0 and enters/stays in CLEAR.
  - flush_i has priority over a decay trigger in the same cycle.
- Decay timer:
  - Increments only in IDLE; clears on entering DECAY or CLEAR.
  - Width is $clog2(DecayPeriod+1).
- busy_o=1 in CLEAR and DECAY; registered from state.
- Updates in IDLE, all computed from pre-cycle values (shct_q):
  - hit_i: counter of hit_sig_i saturating +1 (stays at CntMax).
  - evict_i with evict_reused_i=0: counter of evict_sig_i saturating -1 (stays at 0).
  - evict_i with evict_reused_i=1: no change.
  - fill_i: counter of fill_sig_i := FillVal.
  - Different signatures: all updates apply in the same cycle.
  - Same signature: fill overrides both others; a hit and a dead-evict together leave the counter unchanged.
- Updates while busy_o=1 are dropped. The sweep write is the only table write that cycle.
- Prediction:
  - pred_req_i in cycle N reads shct_q[pred_sig_i], i.e. the value before cycle-N updates.
  - Cycle N+1: pred_valid_o=1, pred_cnt_o=value, pred_reuse_o=(value >= PredThreshold).
  - pred_valid_o=0 when no request was made.
  - If busy_o=1 in cycle N: pred_valid_o=1, pred_reuse_o=0, pred_cnt_o=0.
  - Back-to-back requests are accepted every cycle.
- Arithmetic is unsigned CntWidth; no wrap-around at 0 or CntMax.

Test Plan:
- Reset release -> busy_o=1 for exactly 16384 cycles, then 0; prediction on sig 0x1234 -> pred_valid_o=1, pred_cnt_o=0, pred_reuse_o=0.
- Hit sig 0x0005 four times, then predict -> pred_cnt_o=3 (saturated), pred_reuse_o=1; dead-evict 0x0005 four times -> pred_cnt_o=0, no underflow.
- Same cycle: hit_i and dead evict_i on sig 0x00AA (value 2) -> stays 2; add fill_i on 0x00AA with FillVal=0 -> 0; hit 0x0001 with dead-evict 0x0002 -> both update.
- Predict 0x0010 (value 1) in the same cycle as a hit on 0x0010 -> pred_cnt_o=1; a request the next cycle -> 2.
- DecayPeriod=64, SigWidth=4: set sig 3 to value 3, idle 64 cycles -> busy_o high 16 cycles, then sig 3 reads 1; a hit injected during the sweep is dropped.
- flush_i mid-DECAY at idx 7 -> sweep restarts at 0 in CLEAR; all entries read 0 afterwards; busy_o continuous, with no IDLE gap.
